// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with redirect, prioritised exception vectors and WFI halt.
// Optional feature: define PC_THUMB_EN to add i_thumb (2-byte step, halfword-aligned redirects).
module pc_gen #(
  parameter int unsigned         ADDR_W    = 32,
  parameter int unsigned         N_EXC     = 4,
  parameter logic [ADDR_W-1:0]   RESET_VEC = '0,
  parameter logic [ADDR_W-1:0]   VEC_BASE  = ADDR_W'(32'h0000_0004),
  parameter int unsigned         INC       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_EXC-1:0]  i_exc_req,
  input  logic [N_EXC-1:0]  i_exc_mask,
  input  logic              i_pc_en,
  input  logic [ADDR_W-1:0] i_pc_reg,
  input  logic              i_wfi,
`ifdef PC_THUMB_EN
  input  logic              i_thumb,
`endif
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_next,
  output logic              o_exc_flag,
  output logic [3:0]        o_exc_id,
  output logic [N_EXC-1:0]  o_exc_ack,
  output logic [N_EXC-1:0]  o_pending,
  output logic              o_halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t            state;
  logic [N_EXC-1:0]  eligible;
  logic [N_EXC-1:0]  lowest;
  logic              take;
  logic [3:0]        exc_idx;
  logic [ADDR_W-1:0] vec_addr;
  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] redirect_addr;

  // Two's-complement trick isolates the lowest set bit, i.e. the highest-priority source.
  assign eligible  = o_pending & ~i_exc_mask;
  assign lowest    = eligible & (~eligible + N_EXC'(1));
  assign take      = |eligible;
  assign o_exc_ack = (take && en) ? lowest : '0;
  assign o_halted  = (state == HALT);

  always_comb begin
    exc_idx = '0;
    for (int i = N_EXC - 1; i >= 0; i--) begin
      if (eligible[i]) exc_idx = 4'(i);
    end
  end

  assign vec_addr = VEC_BASE + (ADDR_W'(exc_idx) << 2);

`ifdef PC_THUMB_EN
  assign seq_addr      = o_pc + (i_thumb ? ADDR_W'(2) : ADDR_W'(INC));
  assign redirect_addr = i_pc_reg & ~ADDR_W'(1);
`else
  assign seq_addr      = o_pc + ADDR_W'(INC);
  assign redirect_addr = i_pc_reg;
`endif

  always_comb begin
    o_pc_next = seq_addr;
    if (take)                o_pc_next = vec_addr;
    else if (state == HALT)  o_pc_next = o_pc;
    else if (i_pc_en)        o_pc_next = redirect_addr;
  end

  // Pending bits track requests regardless of en; a same-edge request re-arms a taken bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pc       <= RESET_VEC;
      state      <= RUN;
      o_pending  <= '0;
      o_exc_flag <= 1'b0;
      o_exc_id   <= '0;
    end else begin
      o_pending <= (o_pending & ~o_exc_ack) | i_exc_req;
      if (en) begin
        o_pc       <= o_pc_next;
        o_exc_flag <= take;
        if (take) begin
          o_exc_id <= exc_idx;
          state    <= RUN;
        end else if (state == RUN && i_wfi) begin
          state <= HALT;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen; a reference model predicts every edge.
// Builds with or without PC_THUMB_EN.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, en, pc_en, wfi, thumb;
  logic [3:0]  exc_req, exc_mask;
  logic [31:0] pc_reg;
  logic [31:0] pc, pc_next;
  logic        exc_flag, halted;
  logic [3:0]  exc_id, exc_ack, pending;

  typedef struct {
    logic [31:0] pc;
    logic        halted;
    logic [3:0]  pend;
    logic        flag;
    logic [3:0]  id;
  } exp_t;

  exp_t        sb[$];
  int          n_compared  = 0;
  int          n_mismatched = 0;

  logic [31:0] m_pc;
  logic        m_halt;
  logic [3:0]  m_pend;
  logic        m_flag;
  logic [3:0]  m_id;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .i_exc_req  (exc_req),
    .i_exc_mask (exc_mask),
    .i_pc_en    (pc_en),
    .i_pc_reg   (pc_reg),
    .i_wfi      (wfi),
`ifdef PC_THUMB_EN
    .i_thumb    (thumb),
`endif
    .o_pc       (pc),
    .o_pc_next  (pc_next),
    .o_exc_flag (exc_flag),
    .o_exc_id   (exc_id),
    .o_exc_ack  (exc_ack),
    .o_pending  (pending),
    .o_halted   (halted)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle at the falling edge, predicts from the model, checks after the rising edge.
  task automatic applyStimulus(input logic s_rst, input logic s_en, input logic [3:0] s_req,
                               input logic [3:0] s_mask, input logic s_pc_en,
                               input logic [31:0] s_pc_reg, input logic s_wfi);
    exp_t        e;
    int          k;
    logic [3:0]  elig, exp_ack;
    logic [31:0] exp_next, step, redir;
    @(negedge clk);
    rst = s_rst; en = s_en; exc_req = s_req; exc_mask = s_mask;
    pc_en = s_pc_en; pc_reg = s_pc_reg; wfi = s_wfi;
    elig = m_pend & ~s_mask;
    k = -1;
    for (int i = 0; i < 4; i++) if (elig[i] && k < 0) k = i;
    step  = 32'd4;
    redir = s_pc_reg;
`ifdef PC_THUMB_EN
    if (thumb) step = 32'd2;
    redir[0] = 1'b0;
`endif
    if (k >= 0)      exp_next = 32'h4 + 32'(4 * k);
    else if (m_halt) exp_next = m_pc;
    else if (s_pc_en) exp_next = redir;
    else             exp_next = m_pc + step;
    exp_ack = 4'b0;
    if (k >= 0 && s_en) exp_ack[k] = 1'b1;
    #1;
    if (!s_rst) begin
      checkOutput("pc_next", pc_next, exp_next);
      checkOutput("exc_ack", 32'(exc_ack), 32'(exp_ack));
    end
    if (s_rst) begin
      m_pc = 32'h0; m_halt = 1'b0; m_pend = 4'b0; m_flag = 1'b0; m_id = 4'b0;
    end else begin
      m_pend = (m_pend & ~exp_ack) | s_req;
      if (s_en) begin
        if (k >= 0) begin
          m_pc = exp_next; m_flag = 1'b1; m_id = 4'(k); m_halt = 1'b0;
        end else begin
          m_flag = 1'b0;
          if (!m_halt) begin
            m_pc = exp_next;
            if (s_wfi) m_halt = 1'b1;
          end
        end
      end
    end
    e = '{m_pc, m_halt, m_pend, m_flag, m_id};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput("pc", pc, e.pc);
      checkOutput("halted", 32'(halted), 32'(e.halted));
      checkOutput("pending", 32'(pending), 32'(e.pend));
      checkOutput("exc_flag", 32'(exc_flag), 32'(e.flag));
      checkOutput("exc_id", 32'(exc_id), 32'(e.id));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; exc_req = '0; exc_mask = '0;
    pc_en = 1'b0; pc_reg = '0; wfi = 1'b0; thumb = 1'b0;
    m_pc = '0; m_halt = 1'b0; m_pend = '0; m_flag = 1'b0; m_id = '0;

    // Reset, then sequential stepping
    applyStimulus(1, 0, 4'b0, 4'b0, 0, 32'h0, 0);
    checkOutput("rst_pc", pc, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'b0, 4'b0, 0, 32'h0, 0);
    checkOutput("seq_pc", pc, 32'hC);

    // Redirect wins while the request is only latched; vector follows
    applyStimulus(1, 0, 4'b0, 4'b0, 0, 32'h0, 0);
    applyStimulus(0, 1, 4'b0, 4'b0, 0, 32'h0, 0);
    applyStimulus(0, 1, 4'b0, 4'b0, 0, 32'h0, 0);
    applyStimulus(0, 1, 4'b0100, 4'b0, 1, 32'h100, 0);
    checkOutput("redir_pc", pc, 32'h100);
    applyStimulus(0, 1, 4'b0, 4'b0, 0, 32'h0, 0);
    checkOutput("vec2_pc", pc, 32'h0C);
    checkOutput("vec2_id", 32'(exc_id), 32'd2);

    // Masking and priority
    applyStimulus(0, 0, 4'b1010, 4'b0010, 0, 32'h0, 0);
    applyStimulus(0, 1, 4'b0, 4'b0010, 0, 32'h0, 0);
    checkOutput("vec3_pc", pc, 32'h10);
    applyStimulus(0, 1, 4'b0, 4'b0010, 0, 32'h0, 0);
    applyStimulus(0, 1, 4'b0, 4'b0010, 0, 32'h0, 0);
    checkOutput("masked_pend", 32'(pending), 32'h2);
    applyStimulus(0, 1, 4'b0, 4'b0, 0, 32'h0, 0);
    checkOutput("vec1_pc", pc, 32'h08);

    // WFI halt, wake on exception
    applyStimulus(0, 1, 4'b0, 4'b0, 1, 32'h20, 0);
    applyStimulus(0, 1, 4'b0, 4'b0, 0, 32'h0, 1);
    checkOutput("wfi_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 4'b0, 4'b0, i[0], 32'h500, i[1]);
    checkOutput("halt_pc", pc, 32'h24);
    applyStimulus(0, 1, 4'b0001, 4'b0, 0, 32'h0, 0);
    applyStimulus(0, 1, 4'b0, 4'b0, 0, 32'h0, 0);
    checkOutput("wake_pc", pc, 32'h04);
    checkOutput("wake_halted", 32'(halted), 32'd0);

    // Wrap-around and en=0 hold
    applyStimulus(0, 1, 4'b0, 4'b0, 1, 32'hFFFF_FFFC, 0);
    applyStimulus(0, 1, 4'b0, 4'b0, 0, 32'h0, 0);
    checkOutput("wrap_pc", pc, 32'h0);
    applyStimulus(0, 0, 4'b0010, 4'b0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 4'b0, 4'b0, 1, 32'h700, 1);
    checkOutput("hold_pend", 32'(pending), 32'h2);
    applyStimulus(0, 1, 4'b0, 4'b0, 0, 32'h0, 0);
    checkOutput("vec1b_pc", pc, 32'h08);

    // Reset from HALT discards pending, including a same-cycle request
    applyStimulus(0, 1, 4'b0100, 4'b0100, 0, 32'h0, 1);
    applyStimulus(0, 1, 4'b0, 4'b0100, 0, 32'h0, 0);
    applyStimulus(1, 1, 4'b0001, 4'b0100, 0, 32'h0, 0);
    checkOutput("rst_halt_pc", pc, 32'h0);
    checkOutput("rst_halt_pend", 32'(pending), 32'h0);

`ifdef PC_THUMB_EN
    applyStimulus(0, 1, 4'b0, 4'b0, 1, 32'h101, 0);
    thumb = 1'b1;
    applyStimulus(0, 1, 4'b0, 4'b0, 0, 32'h0, 0);
    applyStimulus(0, 1, 4'b0, 4'b0, 0, 32'h0, 0);
    checkOutput("thumb_pc", pc, 32'h104);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
`ifdef PC_THUMB_EN
      thumb = 1'($urandom);
`endif
      applyStimulus($urandom_range(0, 40) == 0, $urandom_range(0, 5) != 0,
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0,
                    4'($urandom) & 4'($urandom), $urandom_range(0, 3) == 0,
                    $urandom, $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
